// File: rtl/ascii_frame_sequencer.sv
// Streams one frame of cell-buffer brightness IDs as ASCII text:
// cursor-home escape, then ROWS lines of COLS ramp characters ending CR LF.
module ascii_frame_sequencer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [5:0]        rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_dropped
);

    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);

    localparam logic [7:0] RAMP [48] = '{
        8'h20, 8'h2E, 8'h60, 8'h2D, 8'h2C, 8'h3A, 8'h3B, 8'h7E,
        8'h2B, 8'h2F, 8'h3D, 8'h3E, 8'h7C, 8'h28, 8'h29, 8'h5C,
        8'h69, 8'h25, 8'h7B, 8'h2A, 8'h73, 8'h76, 8'h37, 8'h61,
        8'h65, 8'h43, 8'h4A, 8'h4C, 8'h54, 8'h59, 8'h77, 8'h46,
        8'h39, 8'h56, 8'h47, 8'h58, 8'h41, 8'h45, 8'h24, 8'h26,
        8'h23, 8'h40, 8'h52, 8'h57, 8'h30, 8'h4E, 8'h4D, 8'h51
    };

    typedef enum logic [3:0] {
        IDLE, HDR0, HDR1, HDR2, FETCH, LOAD, SEND, CR, LF
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        char_q;
    logic [5:0]        id_clamped;
    logic              last_col;
    logic              last_row;

    assign last_col   = (col == CW'(COLS - 1));
    assign last_row   = (row == RW'(ROWS - 1));
    assign id_clamped = (rd_data > 6'd47) ? 6'd47 : rd_data;
    assign rd_addr    = addr;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nx = state;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        unique case (state)
            IDLE: if (frame_start) state_nx = HDR0;
            HDR0: begin
                tx_valid = 1'b1;
                tx_data  = 8'h1B;
                if (tx_ready) state_nx = HDR1;
            end
            HDR1: begin
                tx_valid = 1'b1;
                tx_data  = 8'h5B;
                if (tx_ready) state_nx = HDR2;
            end
            HDR2: begin
                tx_valid = 1'b1;
                tx_data  = 8'h48;
                if (tx_ready) state_nx = FETCH;
            end
            FETCH: state_nx = LOAD;
            LOAD:  state_nx = SEND;
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = char_q;
                if (tx_ready) state_nx = last_col ? CR : FETCH;
            end
            CR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0D;
                if (tx_ready) state_nx = LF;
            end
            LF: begin
                tx_valid = 1'b1;
                tx_data  = 8'h0A;
                if (tx_ready) state_nx = last_row ? IDLE : FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            addr          <= '0;
            char_q        <= 8'h00;
            frame_done    <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            state         <= state_nx;
            frame_done    <= (state == LF) && tx_ready && last_row;
            frame_dropped <= frame_start && (state != IDLE);
            if (state == IDLE && frame_start) begin
                col  <= '0;
                row  <= '0;
                addr <= '0;
            end
            if (state == LOAD) char_q <= RAMP[id_clamped];
            // Address walks row-major by increment alone
            if (state == SEND && tx_ready) begin
                addr <= addr + 1'b1;
                col  <= last_col ? '0 : col + 1'b1;
            end
            if (state == LF && tx_ready && !last_row) row <= row + 1'b1;
        end
    end

endmodule

// File: tb/tb_ascii_frame_sequencer.sv
// Bench for ascii_frame_sequencer: small 4x2 instance with a byte-stream
// model and directed cases, plus a default-size instance for full length.
module tb_ascii_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        fs_s = 1'b0;
    logic [11:0] rd_addr_s;
    logic [5:0]  rd_data_s = 6'd0;
    logic [7:0]  tx_data_s;
    logic        tx_valid_s;
    logic        tx_ready_s;
    logic        busy_s, done_pulse_s, drop_pulse_s;

    logic        fs_b = 1'b0;
    logic [11:0] rd_addr_b;
    logic [5:0]  rd_data_b = 6'd0;
    logic [7:0]  tx_data_b;
    logic        tx_valid_b;
    logic        busy_b, done_pulse_b, drop_pulse_b;

    logic        rdy_mode = 1'b0;
    logic        rdy_rand = 1'b1;
    assign tx_ready_s = rdy_mode ? rdy_rand : 1'b1;

    ascii_frame_sequencer #(.COLS(4), .ROWS(2), .ADDR_W(12)) dut_s (
        .clk(clk), .rst(rst), .frame_start(fs_s),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s),
        .tx_data(tx_data_s), .tx_valid(tx_valid_s), .tx_ready(tx_ready_s),
        .busy(busy_s), .frame_done(done_pulse_s),
        .frame_dropped(drop_pulse_s)
    );

    ascii_frame_sequencer dut_b (
        .clk(clk), .rst(rst), .frame_start(fs_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(1'b1),
        .busy(busy_b), .frame_done(done_pulse_b),
        .frame_dropped(drop_pulse_b)
    );

    logic [5:0] mem_s [8];
    always @(posedge clk) rd_data_s <= mem_s[rd_addr_s[2:0]];
    always @(posedge clk) rd_data_b <= (rd_addr_b < 12'd2400) ? 6'd10 : 6'd0;
    always @(posedge clk) begin
        #1;
        rdy_rand = 1'($urandom_range(0, 1));
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    string ramp_str = {" .`-,:;~+/=>|()\\", "i%{*sv7aeCJLTYwF",
                       "9VGXAE$&#@RW0NMQ"};

    function automatic logic [7:0] ramp(input int id);
        int k;
        k = (id > 47) ? 47 : id;
        return ramp_str[k];
    endfunction

    logic [7:0] exp_s [$];
    logic [7:0] exp_b [$];
    logic [11:0] addr_log [$];

    task automatic build_frame(input int cols, input int rows,
                               input bit big);
        logic [7:0] q [$];
        q = '{8'h1B, 8'h5B, 8'h48};
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++)
                q.push_back(big ? ramp(10) : ramp(int'(mem_s[r*cols+c])));
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        if (big) exp_b = q;
        else exp_s = q;
    endtask

    bit   chk_s = 0, chk_b = 0;
    int   xfers = 0, busy_cyc_s = 0, done_s = 0, drop_s = 0;
    int   busy_cyc_b = 0, done_b = 0;
    bit   held = 0;
    logic [7:0] held_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (chk_s) begin
                if (busy_s) busy_cyc_s++;
                if (done_pulse_s) done_s++;
                if (drop_pulse_s) drop_s++;
                if (held) begin
                    check("hold_valid", 32'(tx_valid_s), 32'd1);
                    check("hold_data", 32'(tx_data_s), 32'(held_data));
                end
                if (busy_s && !tx_valid_s &&
                    (addr_log.size() == 0 || addr_log[$] != rd_addr_s))
                    addr_log.push_back(rd_addr_s);
                if (tx_valid_s && tx_ready_s) begin
                    xfers++;
                    if (exp_s.size() == 0)
                        check("extra_byte", 32'(tx_data_s), 32'hFFFF);
                    else
                        check("byte_s", 32'(tx_data_s), 32'(exp_s.pop_front()));
                end
                held = tx_valid_s && !tx_ready_s;
                held_data = tx_data_s;
            end
            if (chk_b) begin
                if (busy_b) busy_cyc_b++;
                if (done_pulse_b) done_b++;
                if (tx_valid_b) begin
                    if (exp_b.size() == 0)
                        check("extra_byte_b", 32'(tx_data_b), 32'hFFFF);
                    else
                        check("byte_b", 32'(tx_data_b), 32'(exp_b.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_s();
        fs_s = 1'b1;
        tick();
        fs_s = 1'b0;
    endtask

    task automatic start_test();
        xfers = 0;
        busy_cyc_s = 0;
        done_s = 0;
        drop_s = 0;
        addr_log.delete();
        build_frame(4, 2, 1'b0);
        chk_s = 1;
    endtask

    task automatic wait_done_s(input string nm, input int budget);
        int n = 0;
        while (done_s == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_s == 0) check({nm, "_timeout"}, 32'd0, 32'd1);
        repeat (4) tick();
        check({nm, "_busy_after"}, 32'(busy_s), 32'd0);
        check({nm, "_left"}, 32'(exp_s.size()), 32'd0);
        check({nm, "_done_cnt"}, 32'(done_s), 32'd1);
        chk_s = 0;
    endtask

    logic [7:0] lit [15] = '{8'h1B, 8'h5B, 8'h48, 8'h20, 8'h2E, 8'h60,
                             8'h2D, 8'h0D, 8'h0A, 8'h51, 8'h51, 8'h51,
                             8'h69, 8'h0D, 8'h0A};

    initial begin
        mem_s = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd47, 6'd48, 6'd63, 6'd16};
        repeat (3) tick();
        check("rst_valid", 32'(tx_valid_s), 32'd0);
        check("rst_data", 32'(tx_data_s), 32'd0);
        check("rst_addr", 32'(rd_addr_s), 32'd0);
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_done", 32'(done_pulse_s), 32'd0);
        check("rst_drop", 32'(drop_pulse_s), 32'd0);
        rst = 1'b0;
        tick();

        // Basic frame; model pinned against hand-computed stream
        start_test();
        check("model_len", 32'(exp_s.size()), 32'd15);
        for (int i = 0; i < 15; i++)
            check($sformatf("model_%0d", i), 32'(exp_s[i]), 32'(lit[i]));
        pulse_s();
        check("lat_valid", 32'(tx_valid_s), 32'd1);
        check("lat_data", 32'(tx_data_s), 32'h1B);
        check("lat_busy", 32'(busy_s), 32'd1);
        wait_done_s("basic", 200);
        check("basic_cycles", 32'(busy_cyc_s), 32'd31);
        check("basic_xfers", 32'(xfers), 32'd15);
        check("addr_cnt", 32'(addr_log.size()), 32'd8);
        for (int i = 0; i < addr_log.size() && i < 8; i++)
            check($sformatf("addr_%0d", i), 32'(addr_log[i]), 32'(i));

        // Backpressure
        rdy_mode = 1'b1;
        start_test();
        pulse_s();
        wait_done_s("stall", 1000);
        rdy_mode = 1'b0;
        tick();

        // Second start mid-frame is dropped
        start_test();
        pulse_s();
        repeat (9) tick();
        pulse_s();
        wait_done_s("drop", 200);
        check("drop_cnt", 32'(drop_s), 32'd1);
        check("drop_cycles", 32'(busy_cyc_s), 32'd31);

        // Reset while SEND in row 1
        start_test();
        pulse_s();
        for (int n = 0; n < 100 && !(xfers == 10 && tx_valid_s); n++)
            tick();
        check("mid_reached", 32'(xfers == 10 && tx_valid_s), 32'd1);
        chk_s = 0;
        rst = 1'b1;
        tick();
        check("mrst_valid", 32'(tx_valid_s), 32'd0);
        check("mrst_busy", 32'(busy_s), 32'd0);
        check("mrst_addr", 32'(rd_addr_s), 32'd0);
        rst = 1'b0;
        tick();
        start_test();
        pulse_s();
        wait_done_s("after_rst", 200);
        check("after_rst_xfers", 32'(xfers), 32'd15);

        // Default-size frame
        build_frame(80, 30, 1'b1);
        check("big_len", 32'(exp_b.size()), 32'd2463);
        chk_b = 1;
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        for (int n = 0; n < 8000 && done_b == 0; n++) tick();
        repeat (3) tick();
        check("big_done", 32'(done_b), 32'd1);
        check("big_cycles", 32'(busy_cyc_b), 32'd7263);
        check("big_left", 32'(exp_b.size()), 32'd0);
        check("big_busy_after", 32'(busy_b), 32'd0);
        chk_b = 0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
